qbu_rx_ts_store: RTL and testbench
==================================

QBU_RX_TS_STORE -- requirements
Module: qbu_rx_ts_store

Interface
REQ-001 Parameter TS_WIDTH, default 64, width of system time / stored timestamp in ns.
REQ-002 Parameter LAT_COMP, default 2, cycles of ns subtracted from captured time to back-date to SFD detection.
REQ-003 Parameter CLK_PERIOD_NS, default 8, ns per i_clk cycle, used with LAT_COMP.
REQ-004 i_clk  input  1  clock; all logic on rising edge.
REQ-005 i_rst  input  1  reset, asynchronous, active-high.
REQ-006 i_sys_time  input  TS_WIDTH  free-running PTP time in ns.
REQ-007 i_mac_time_irq  input  1  single-cycle capture pulse from rx timestamp trigger stage.
REQ-008 i_mac_frame_seq  input  8  frame sequence number accompanying the pulse.
REQ-009 i_timestamp_addr  input  7  slot index accompanying the pulse.
REQ-010 i_rd_req  input  1  single-cycle CPU read request.
REQ-011 i_rd_addr  input  7  slot to read, sampled with i_rd_req.
REQ-012 o_rd_data  output  8+TS_WIDTH  {seq[7:0], timestamp}.
REQ-013 o_rd_valid  output  1  one-cycle strobe qualifying o_rd_data and o_rd_hit.
REQ-014 o_rd_hit  output  1  slot held an unread entry at read issue.
REQ-015 o_ts_pending  output  8  count of unread slots, 0..128.
REQ-016 o_ts_irq  output  1  level, high while o_ts_pending != 0.
REQ-017 o_overflow  output  1  sticky, unread slot overwritten.
REQ-018 i_ovf_clr  input  1  single-cycle clear of o_overflow.

Function
REQ-019 On i_mac_time_irq, store {i_mac_frame_seq, i_sys_time - LAT_COMP*CLK_PERIOD_NS} (modulo 2^TS_WIDTH) at i_timestamp_addr in the same cycle.
REQ-020 Maintain a 128-bit valid map; a write sets the slot bit.
REQ-021 Write to a slot already valid: overwrite data, set o_overflow, o_ts_pending unchanged.
REQ-022 Write to an invalid slot: o_ts_pending +1 next cycle.
REQ-023 Read: i_rd_req in cycle N gives o_rd_valid=1 with o_rd_data, o_rd_hit in cycle N+2 (RAM register + output register); back-to-back requests every cycle supported.
REQ-024 Read of a valid slot clears its bit and decrements o_ts_pending; read of invalid slot returns RAM contents, o_rd_hit=0, no count change.
REQ-025 Write and read to same slot same cycle: read returns pre-write data (read-first), bit remains set, o_rd_hit reflects prior bit, no overflow, pending net +0 if prior bit set, +1 if not.
REQ-026 Write and read to different slots same cycle: both take effect; pending adjusts by +1/-1 independently (net 0 when both apply).
REQ-027 o_ts_pending saturates at 128 and never underflows below 0.
REQ-028 o_overflow set and i_ovf_clr in same cycle: set wins.
REQ-029 o_ts_irq is registered, asserted/deasserted the cycle after o_ts_pending changes to/from 0.

Reset
REQ-030 While i_rst high: valid map cleared, o_ts_pending=0, o_ts_irq=0, o_overflow=0, o_rd_valid=0, o_rd_hit=0, o_rd_data=0.
REQ-031 Reset mid-read drops in-flight requests; no o_rd_valid after release for them.
REQ-032 RAM contents are not reset; only the valid map governs hits.

Structure
REQ-033 Package qbu_rx_ts_pkg holds TS_WIDTH default, SEQ_W=8, ADDR_W=7, DEPTH=128, entry width SEQ_W+TS_WIDTH.
REQ-034 Sub-module qbu_rx_ts_ram: simple dual-port, 128 x entry, read-first, registered 1-cycle read; all control in qbu_rx_ts_store.

Verification
REQ-035 Irq at addr 5, seq 0x11, sys_time 1000 -> read addr 5 two cycles later: o_rd_data={0x11, 984}, o_rd_hit=1, pending 1->0, o_ts_irq falls.
REQ-036 Two irqs to addr 3 unread -> o_overflow=1, pending=1, read returns second seq; i_ovf_clr then clears.
REQ-037 128 writes addr 0..127, 0..127 reads -> pending 128 then 0; wrap write to addr 0 after reads gives no overflow.
REQ-038 Same-cycle write and read at addr 9 (previously valid, seq 0x20, new seq 0x21) -> o_rd_data seq 0x20, o_rd_hit=1, bit remains set, pending unchanged.
REQ-039 Read of never-written addr 100 -> o_rd_valid=1, o_rd_hit=0, pending unchanged.
REQ-040 Assert i_rst one cycle after i_rd_req with pending=4 -> no o_rd_valid, pending=0, o_ts_irq=0, o_overflow=0.

Source files
------------

// File: rtl/qbu_rx_ts_pkg.sv
// qbu_rx_ts_pkg: shared widths and depth for the rx timestamp store
package qbu_rx_ts_pkg;
  localparam int TS_W_DEF = 64;
  localparam int SEQ_W = 8;
  localparam int ADDR_W = 7;
  localparam int DEPTH = 128;
  localparam int ENTRY_W_DEF = SEQ_W + TS_W_DEF;
endpackage

// File: rtl/qbu_rx_ts_ram.sv
// qbu_rx_ts_ram: 128-entry simple dual-port RAM, read-first, registered read
// Ports: clk; we/waddr/wdata write port; re/raddr read port; rdata valid one cycle after re.
module qbu_rx_ts_ram
  import qbu_rx_ts_pkg::*;
#(
  parameter int W = ENTRY_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [W-1:0]      wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [W-1:0]      rdata
);
  logic [W-1:0] mem [DEPTH];
  // Non-blocking write means a same-address read sees the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/qbu_rx_ts_store.sv
// qbu_rx_ts_store: per-slot rx timestamp store with valid map, pending count and overflow
// Ports: i_clk/i_rst (async, active-high); capture i_mac_time_irq/i_mac_frame_seq/i_timestamp_addr
// with i_sys_time; read i_rd_req/i_rd_addr -> o_rd_valid/o_rd_data/o_rd_hit two cycles later;
// status o_ts_pending, o_ts_irq, sticky o_overflow cleared by i_ovf_clr.
module qbu_rx_ts_store
  import qbu_rx_ts_pkg::*;
#(
  parameter int TS_WIDTH = TS_W_DEF,
  parameter int LAT_COMP = 2,
  parameter int CLK_PERIOD_NS = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [TS_WIDTH-1:0]       i_sys_time,
  input  logic                      i_mac_time_irq,
  input  logic [SEQ_W-1:0]          i_mac_frame_seq,
  input  logic [ADDR_W-1:0]         i_timestamp_addr,
  input  logic                      i_rd_req,
  input  logic [ADDR_W-1:0]         i_rd_addr,
  output logic [SEQ_W+TS_WIDTH-1:0] o_rd_data,
  output logic                      o_rd_valid,
  output logic                      o_rd_hit,
  output logic [7:0]                o_ts_pending,
  output logic                      o_ts_irq,
  output logic                      o_overflow,
  input  logic                      i_ovf_clr
);
  localparam int EW = SEQ_W + TS_WIDTH;
  localparam logic [TS_WIDTH-1:0] ADJ = TS_WIDTH'(LAT_COMP * CLK_PERIOD_NS);
  localparam logic [DEPTH-1:0] ONE = {{(DEPTH-1){1'b0}}, 1'b1};
  logic [DEPTH-1:0] valid, set_m, clr_m;
  logic [EW-1:0] ram_q;
  logic same, inc, dec, ovf_set, rd_v1, hit1;
  // A read colliding with a write to the same slot keeps the bit set, so it
  // neither consumes the entry nor counts as an overwrite.
  always_comb begin
    same = i_mac_time_irq && i_rd_req && (i_timestamp_addr == i_rd_addr);
    inc = i_mac_time_irq && !valid[i_timestamp_addr];
    dec = i_rd_req && valid[i_rd_addr] && !same;
    ovf_set = i_mac_time_irq && valid[i_timestamp_addr] && !same;
    set_m = i_mac_time_irq ? ONE << i_timestamp_addr : '0;
    clr_m = dec ? ONE << i_rd_addr : '0;
  end
  qbu_rx_ts_ram #(.W(EW)) u_ram (
    .clk(i_clk),
    .we(i_mac_time_irq),
    .waddr(i_timestamp_addr),
    .wdata({i_mac_frame_seq, i_sys_time - ADJ}),
    .re(i_rd_req),
    .raddr(i_rd_addr),
    .rdata(ram_q)
  );
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid <= '0;
      o_ts_pending <= '0;
      o_ts_irq <= 1'b0;
      o_overflow <= 1'b0;
      rd_v1 <= 1'b0;
      hit1 <= 1'b0;
      o_rd_valid <= 1'b0;
      o_rd_hit <= 1'b0;
      o_rd_data <= '0;
    end else begin
      valid <= (valid & ~clr_m) | set_m;
      o_ts_pending <= (inc && !dec && o_ts_pending != 8'(DEPTH)) ? o_ts_pending + 8'd1 :
                      (dec && !inc && o_ts_pending != 8'd0) ? o_ts_pending - 8'd1 : o_ts_pending;
      o_ts_irq <= o_ts_pending != 8'd0;
      o_overflow <= ovf_set || (o_overflow && !i_ovf_clr);
      rd_v1 <= i_rd_req;
      hit1 <= i_rd_req && valid[i_rd_addr];
      o_rd_valid <= rd_v1;
      o_rd_hit <= rd_v1 && hit1;
      if (rd_v1) o_rd_data <= ram_q;
    end
  end
endmodule

// File: tb/tb_qbu_rx_ts_store.sv
// tb_qbu_rx_ts_store: directed and random checks of the rx timestamp store against a slot model
module tb_qbu_rx_ts_store;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic [63:0] i_sys_time = '0;
  logic i_mac_time_irq = 1'b0;
  logic [7:0] i_mac_frame_seq = '0;
  logic [6:0] i_timestamp_addr = '0;
  logic i_rd_req = 1'b0;
  logic [6:0] i_rd_addr = '0;
  logic [71:0] o_rd_data;
  logic o_rd_valid, o_rd_hit, o_ts_irq, o_overflow;
  logic [7:0] o_ts_pending;
  logic i_ovf_clr = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [7:0] mseq [128];
  logic [63:0] mts [128];
  bit mval [128];
  bit mknown [128];
  bit movf;
  bit p_re, p_hit, p_known;
  logic [71:0] p_data;
  qbu_rx_ts_store dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_sys_time(i_sys_time),
    .i_mac_time_irq(i_mac_time_irq), .i_mac_frame_seq(i_mac_frame_seq),
    .i_timestamp_addr(i_timestamp_addr), .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .o_rd_hit(o_rd_hit),
    .o_ts_pending(o_ts_pending), .o_ts_irq(o_ts_irq), .o_overflow(o_overflow),
    .i_ovf_clr(i_ovf_clr)
  );
  always #5 i_clk = ~i_clk;
  function automatic int cnt();
    int n = 0;
    for (int i = 0; i < 128; i++) n += int'(mval[i]);
    return n;
  endfunction
  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input bit we, input int wa, input logic [7:0] sq, input logic [63:0] st,
                     input bit re, input int ra, input bit oc);
    int old;
    bit c_hit, c_known;
    logic [71:0] c_data;
    i_mac_time_irq = we; i_timestamp_addr = 7'(wa); i_mac_frame_seq = sq; i_sys_time = st;
    i_rd_req = re; i_rd_addr = 7'(ra); i_ovf_clr = oc;
    old = cnt();
    c_hit = re && mval[ra];
    c_known = mknown[ra];
    c_data = {mseq[ra], mts[ra]};
    if (we && mval[wa] && !(re && ra == wa)) movf = 1'b1;
    else if (oc) movf = 1'b0;
    if (re && !(we && wa == ra)) mval[ra] = 1'b0;
    if (we) begin
      mval[wa] = 1'b1; mknown[wa] = 1'b1; mseq[wa] = sq; mts[wa] = st - 64'd16;
    end
    @(negedge i_clk);
    chk("pending", 72'(o_ts_pending), 72'(cnt()));
    chk("overflow", 72'(o_overflow), 72'(movf));
    chk("ts_irq", 72'(o_ts_irq), 72'(old != 0));
    chk("rd_valid", 72'(o_rd_valid), 72'(p_re));
    if (p_re) begin
      chk("rd_hit", 72'(o_rd_hit), 72'(p_hit));
      if (p_known) chk("rd_data", o_rd_data, p_data);
    end
    p_re = re; p_hit = c_hit; p_known = c_known; p_data = c_data;
  endtask
  task automatic idle();
    cyc(0, 0, 8'h0, 64'd0, 0, 0, 0);
  endtask
  task automatic rst_cyc();
    i_rst = 1'b1;
    i_mac_time_irq = 0; i_rd_req = 0; i_ovf_clr = 0;
    @(negedge i_clk);
    chk("rst_pending", 72'(o_ts_pending), 72'(0));
    chk("rst_irq", 72'(o_ts_irq), 72'(0));
    chk("rst_ovf", 72'(o_overflow), 72'(0));
    chk("rst_valid", 72'(o_rd_valid), 72'(0));
    chk("rst_hit", 72'(o_rd_hit), 72'(0));
    chk("rst_data", o_rd_data, 72'(0));
    i_rst = 1'b0;
    for (int i = 0; i < 128; i++) mval[i] = 1'b0;
    movf = 1'b0; p_re = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 128; i++) begin mknown[i] = 0; mval[i] = 0; end
    movf = 0; p_re = 0;
    @(negedge i_clk);
    rst_cyc();
    cyc(1, 5, 8'h11, 64'd1000, 0, 0, 0);
    idle();
    cyc(0, 0, 8'h0, 64'd1010, 1, 5, 0);
    idle();
    chk("d35_data", o_rd_data, {8'h11, 64'd984});
    chk("d35_hit", 72'(o_rd_hit), 72'(1));
    idle();
    chk("d35_irq", 72'(o_ts_irq), 72'(0));
    cyc(1, 3, 8'h31, 64'd2000, 0, 0, 0);
    cyc(1, 3, 8'h32, 64'd2100, 0, 0, 0);
    chk("d36_ovf", 72'(o_overflow), 72'(1));
    chk("d36_pend", 72'(o_ts_pending), 72'(1));
    cyc(0, 0, 8'h0, 64'd0, 1, 3, 0);
    idle();
    chk("d36_seq", 72'(o_rd_data[71:64]), 72'(8'h32));
    cyc(0, 0, 8'h0, 64'd0, 0, 0, 1);
    chk("d36_clr", 72'(o_overflow), 72'(0));
    cyc(1, 9, 8'h20, 64'd3000, 0, 0, 0);
    idle();
    cyc(1, 9, 8'h21, 64'd3100, 1, 9, 0);
    idle();
    chk("d38_seq", 72'(o_rd_data[71:64]), 72'(8'h20));
    chk("d38_hit", 72'(o_rd_hit), 72'(1));
    cyc(0, 0, 8'h0, 64'd0, 1, 100, 0);
    idle();
    chk("d39_valid", 72'(o_rd_valid), 72'(1));
    chk("d39_hit", 72'(o_rd_hit), 72'(0));
    for (int i = 0; i < 400; i++) begin
      cyc(bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 8'($urandom),
          ($urandom_range(0, 7) == 0) ? 64'($urandom_range(0, 20)) : {$urandom, $urandom},
          bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)), $urandom_range(0, 5) == 0);
    end
    idle();
    idle();
    rst_cyc();
    for (int a = 0; a < 128; a++) cyc(1, a, 8'(a), 64'(a * 100 + 7), 0, 0, 0);
    chk("d37_full", 72'(o_ts_pending), 72'(128));
    for (int a = 0; a < 128; a++) cyc(0, 0, 8'h0, 64'd0, 1, a, 0);
    idle();
    idle();
    chk("d37_empty", 72'(o_ts_pending), 72'(0));
    cyc(1, 0, 8'h55, 64'd5, 0, 0, 0);
    chk("d37_noovf", 72'(o_overflow), 72'(0));
    rst_cyc();
    for (int a = 20; a < 24; a++) cyc(1, a, 8'(a), 64'd9000, 0, 0, 0);
    chk("d40_pend4", 72'(o_ts_pending), 72'(4));
    cyc(1, 20, 8'h99, 64'd9100, 1, 21, 0);
    rst_cyc();
    idle();
    idle();
    idle();
    chk("d40_novalid", 72'(o_rd_valid), 72'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
